// File: rtl/multi_phase_traffic_controller.sv
// multi_phase_traffic_controller: round-robin GREEN/YELLOW/ALL-RED sequencer over NUM_ROADS approaches.
// Define TRAFFIC_PED_CROSSING_EN to add a pedestrian WALK phase (ped_req/walk, PED_TICKS).
module multi_phase_traffic_controller #(
    parameter int NUM_ROADS       = 4,
    parameter int TICK_DIV        = 50_000_000,
    parameter int GREEN_MIN_TICKS = 10,
    parameter int YELLOW_TICKS    = 3,
    parameter int ALLRED_TICKS    = 1,
    parameter int CNT_W           = 16
`ifdef TRAFFIC_PED_CROSSING_EN
    ,
    parameter int PED_TICKS       = 8
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ROADS-1:0]         req,
    output logic [3*NUM_ROADS-1:0]       lights,
    output logic [$clog2(NUM_ROADS)-1:0] phase,
    output logic [1:0]                   state
`ifdef TRAFFIC_PED_CROSSING_EN
    ,
    input  logic                         ped_req,
    output logic                         walk
`endif
);
    localparam int PW = $clog2(NUM_ROADS);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_ALLRED = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10
`ifdef TRAFFIC_PED_CROSSING_EN
        ,
        S_PED    = 2'b11
`endif
    } state_t;

    state_t                 r_state, w_state;
    logic [PW-1:0]          r_phase, w_phase, w_sel, w_idx;
    logic [DW-1:0]          r_pre;
    logic [CNT_W-1:0]       r_el, w_el;
    logic [NUM_ROADS-1:0]   r_pend, w_pend, w_busy, w_enter;
    logic [3*NUM_ROADS-1:0] r_lights, w_lights;
    logic                   w_tick, w_other;
`ifdef TRAFFIC_PED_CROSSING_EN
    logic                   r_ped_pend, r_walk;
`endif

    assign w_tick = (r_pre == DW'(TICK_DIV - 1));
    assign w_busy = (r_state == S_GREEN || r_state == S_YELLOW) ? (NUM_ROADS'(1) << r_phase) : '0;
`ifdef TRAFFIC_PED_CROSSING_EN
    assign w_other = (|(r_pend & ~w_busy)) | r_ped_pend;
`else
    assign w_other = |(r_pend & ~w_busy);
`endif

    // Nearest pending road after the current one; the descending scan lets the closest win.
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        for (int k = NUM_ROADS; k >= 1; k--) begin
            w_idx = PW'((int'(r_phase) + k) % NUM_ROADS);
            if (r_pend[w_idx]) w_sel = w_idx;
        end
    end

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        case (r_state)
            S_ALLRED:
                if (w_tick && r_el == CNT_W'(ALLRED_TICKS - 1)) begin
`ifdef TRAFFIC_PED_CROSSING_EN
                    if (r_ped_pend) w_state = S_PED;
                    else
`endif
                    begin
                        w_state = S_GREEN;
                        w_phase = w_sel;
                    end
                end
            S_GREEN:
                if (w_tick && r_el >= CNT_W'(GREEN_MIN_TICKS - 1) && w_other) w_state = S_YELLOW;
            S_YELLOW:
                if (w_tick && r_el == CNT_W'(YELLOW_TICKS - 1)) w_state = S_ALLRED;
`ifdef TRAFFIC_PED_CROSSING_EN
            S_PED:
                if (w_tick && r_el == CNT_W'(PED_TICKS - 1)) w_state = S_ALLRED;
`endif
            default: w_state = S_ALLRED;
        endcase
    end

    assign w_el    = (w_state != r_state) ? '0 :
                     (w_tick && r_el != '1) ? r_el + CNT_W'(1) : r_el;
    assign w_enter = (w_state == S_GREEN && r_state != S_GREEN) ? (NUM_ROADS'(1) << w_phase) : '0;
    assign w_pend  = (r_pend | (req & ~w_busy)) & ~w_enter;

    // Lights are decoded from the next state so they register on the same edge as state.
    always_comb begin
        w_lights = '0;
        for (int i = 0; i < NUM_ROADS; i++)
            w_lights[3*i +: 3] = (w_phase != PW'(i)) ? 3'b100 :
                                 (w_state == S_GREEN) ? 3'b001 :
                                 (w_state == S_YELLOW) ? 3'b010 : 3'b100;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_ALLRED;
            r_phase  <= PW'(NUM_ROADS - 1);
            r_pre    <= '0;
            r_el     <= '0;
            r_pend   <= '0;
            r_lights <= {NUM_ROADS{3'b100}};
        end else begin
            r_state  <= w_state;
            r_phase  <= w_phase;
            r_pre    <= w_tick ? '0 : r_pre + DW'(1);
            r_el     <= w_el;
            r_pend   <= w_pend;
            r_lights <= w_lights;
        end
    end

`ifdef TRAFFIC_PED_CROSSING_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ped_pend <= 1'b0;
            r_walk     <= 1'b0;
        end else begin
            r_ped_pend <= (r_ped_pend | ped_req) & ~(w_state == S_PED && r_state != S_PED);
            r_walk     <= (w_state == S_PED);
        end
    end

    assign walk = r_walk;
`endif

    assign lights = r_lights;
    assign phase  = r_phase;
    assign state  = r_state;
endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// tb_multi_phase_traffic_controller: directed scenarios plus random requests against a cycle-count model.
module tb_multi_phase_traffic_controller;
    localparam int N = 4, TD = 2, GM = 4, YT = 2, AT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [11:0] lights;
    logic [1:0]  phase, state;
`ifdef TRAFFIC_PED_CROSSING_EN
    logic        ped_req = 1'b0;
    logic        walk;
`endif

    int total = 0, bad = 0;
    int m_mode, m_ph, m_cin;
    logic [3:0] m_pend;

    always #5 clk = ~clk;

    multi_phase_traffic_controller #(
        .NUM_ROADS(N), .TICK_DIV(TD), .GREEN_MIN_TICKS(GM),
        .YELLOW_TICKS(YT), .ALLRED_TICKS(AT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lights(lights), .phase(phase), .state(state)
`ifdef TRAFFIC_PED_CROSSING_EN
        , .ped_req(ped_req), .walk(walk)
`endif
    );

    function automatic logic [11:0] exp_lights(input int mode, input int ph);
        logic [11:0] v;
        v = 12'h924;
        if (mode == 1) v[3*ph +: 3] = 3'b001;
        if (mode == 2) v[3*ph +: 3] = 3'b010;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_len(input logic [11:0] v, input int lim, output int n);
        n = 0;
        while (lights == v && n < lim) begin
            @(negedge clk);
            req = 4'b0;
            n++;
        end
    endtask

    // Model: mode durations counted in clk cycles; every mode begins on a tick boundary.
    initial forever begin
        int nm, np;
        bit found;
        logic [3:0] busy;
        @(posedge clk);
        if (!rst) begin
            m_mode = 0; m_ph = N - 1; m_cin = 0; m_pend = 4'b0;
        end else begin
            nm = m_mode; np = m_ph;
            busy = (m_mode != 0) ? 4'(1 << m_ph) : 4'b0;
            if (m_mode == 0 && m_cin + 1 == AT * TD) begin
                nm = 1; np = 0; found = 0;
                for (int k = 1; k <= N; k++)
                    if (!found && m_pend[(m_ph + k) % N]) begin
                        np = (m_ph + k) % N; found = 1;
                    end
            end else if (m_mode == 1 && (m_cin + 1) % TD == 0 && m_cin + 1 >= GM * TD && (m_pend & ~busy) != 0)
                nm = 2;
            else if (m_mode == 2 && m_cin + 1 == YT * TD)
                nm = 0;
            m_pend = m_pend | (req & ~busy);
            if (nm == 1 && m_mode != 1) m_pend[np] = 1'b0;
            m_cin = (nm != m_mode) ? 0 : m_cin + 1;
            m_mode = nm; m_ph = np;
        end
        #1;
        check("model_lights", 32'(lights), 32'(exp_lights(m_mode, m_ph)));
        check("model_state", 32'(state), 32'(m_mode));
        check("model_phase", 32'(phase), 32'(m_ph));
    end

    initial begin
        int n;
        repeat (5) @(negedge clk);
        check("rst_lights", 32'(lights), 32'h924);
        check("rst_state", 32'(state), 0);
        check("rst_phase", 32'(phase), 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("first_green", 32'(lights), 32'h921);
        check("first_phase", 32'(phase), 0);
        run_len(12'h921, 120, n);
        check("green_rest_len", n, 120);
        req = 4'b0100;
        run_len(12'h921, 20, n);
        check("r0_yellow", 32'(lights), 32'h922);
        run_len(12'h922, 20, n);
        check("r0_yellow_len", n, 4);
        check("allred_a", 32'(lights), 32'h924);
        run_len(12'h924, 20, n);
        check("allred_a_len", n, 2);
        check("r2_green", 32'(lights), 32'h864);
        check("r2_phase", 32'(phase), 2);
        req = 4'b1110;
        run_len(12'h864, 40, n);
        check("min_green_len", n, 8);
        check("r2_yellow", 32'(lights), 32'h8A4);
        run_len(12'h8A4, 20, n);
        run_len(12'h924, 20, n);
        check("rr_r3_green", 32'(lights), 32'h324);
        check("rr_r3_phase", 32'(phase), 3);
        run_len(12'h324, 40, n);
        check("r3_green_len", n, 8);
        check("r3_yellow", 32'(lights), 32'h524);
        run_len(12'h524, 20, n);
        run_len(12'h924, 20, n);
        check("rr_r1_green", 32'(lights), 32'h90C);
        run_len(12'h90C, 50, n);
        check("own_req_ignored", n, 50);
        req = 4'b0001;
        run_len(12'h90C, 40, n);
        check("r1_yellow", 32'(lights), 32'h914);
        run_len(12'h914, 20, n);
        run_len(12'h924, 20, n);
        check("r0_green_again", 32'(lights), 32'h921);
        req = 4'b1000;
        run_len(12'h921, 40, n);
        check("r0_yellow_b", 32'(lights), 32'h922);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_lights", 32'(lights), 32'h924);
        check("midrst_state", 32'(state), 0);
        check("midrst_phase", 32'(phase), 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("pend_cleared", 32'(lights), 32'h921);
        run_len(12'h921, 30, n);
        check("pend_cleared_hold", n, 30);
        repeat (3000) begin
            @(negedge clk);
            req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            rst = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0;
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
